// File: rtl/fifo_rr_arbiter_if.sv
// Handshake bundle between the upstream FIFO bank, the round-robin arbiter and
// the merged downstream FIFO.
interface fifo_rr_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 6
);
    logic [NREQ-1:0]    up_empty;
    logic [NREQ*DW-1:0] up_data;
    logic [NREQ-1:0]    up_pop;
    logic               dn_pausa;
    logic               dn_full;
    logic               dn_push;
    logic [DW-1:0]      dn_data;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic               err_ovf;

    modport master (
        input  up_empty, up_data, dn_pausa, dn_full,
        output up_pop, dn_push, dn_data, grant, busy, err_ovf
    );

    modport slave (
        output up_empty, up_data, dn_pausa, dn_full,
        input  up_pop, dn_push, dn_data, grant, busy, err_ovf
    );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin burst arbiter draining NREQ upstream FIFOs into one downstream FIFO.
// Pop at t, upstream word at t+1, registered push/data at t+2.
module fifo_rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned BURST = 4,
    parameter int unsigned DW    = 6
) (
    input  logic               clk,
    input  logic               reset,
    fifo_rr_arbiter_if.master  bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(BURST + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_GAP} state_t;

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   src;
    logic [CW-1:0]   cnt;
    logic            fly;

    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    logic [IW-1:0]   scan_idx;
    logic            do_start;
    logic            do_pop;
    logic            do_rel;
    logic            busy_n;

    logic [DW-1:0]   up_word [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign up_word[i] = bus.up_data[i*DW +: DW];
    end

    // First non-empty FIFO scanning upward from rr_ptr with wrap.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_ptr;
        scan_idx  = rr_ptr;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            scan_idx = IW'((int'(rr_ptr) + k) % int'(NREQ));
            if (!bus.up_empty[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    // Transition decisions; GAP gives the upstream empty flag time to settle.
    always_comb begin
        state_n  = state;
        do_start = 1'b0;
        do_pop   = 1'b0;
        do_rel   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!bus.dn_pausa && sel_found) begin
                    do_start = 1'b1;
                    state_n  = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!bus.up_empty[gidx] && !bus.dn_pausa) begin
                    do_pop  = 1'b1;
                    state_n = ST_GAP;
                end else begin
                    do_rel  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt == CW'(BURST)) begin
                    do_rel  = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_BURST;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // After the edge: pop strobe -> fly -> push, any of them keeps us busy.
        busy_n = (state_n != ST_IDLE) || (bus.up_pop != '0) || fly;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            gidx        <= '0;
            src         <= '0;
            cnt         <= '0;
            fly         <= 1'b0;
            bus.up_pop  <= '0;
            bus.dn_push <= 1'b0;
            bus.dn_data <= '0;
            bus.grant   <= '0;
            bus.busy    <= 1'b0;
            bus.err_ovf <= 1'b0;
        end else begin
            state       <= state_n;
            bus.up_pop  <= do_pop ? (NREQ'(1) << gidx) : '0;
            bus.busy    <= busy_n;
            bus.err_ovf <= bus.err_ovf | (bus.dn_push & bus.dn_full);
            fly         <= (bus.up_pop != '0);
            bus.dn_push <= fly;
            if (fly) begin
                bus.dn_data <= up_word[src];
            end
            if (do_start) begin
                bus.grant <= NREQ'(1) << sel_idx;
                gidx      <= sel_idx;
                cnt       <= '0;
            end
            if (do_pop) begin
                cnt <= cnt + CW'(1);
                src <= gidx;
            end
            if (do_rel) begin
                bus.grant <= '0;
                rr_ptr    <= IW'((int'(gidx) + 1) % int'(NREQ));
            end
        end
    end
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: upstream FIFO models, a monitor logging
// pops/pushes/grants, a vector table of drain scenarios and corner sequences.
module tb_fifo_rr_arbiter;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned BURST = 4;
    localparam int unsigned DW    = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_rr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    fifo_rr_arbiter #(.NREQ(NREQ), .BURST(BURST), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Upstream FIFO models: word k of FIFO i carries value i*16+k.
    int            fcnt [4] = '{0, 0, 0, 0};
    int            frd  [4] = '{0, 0, 0, 0};
    logic [DW-1:0] fout [4] = '{6'd0, 6'd0, 6'd0, 6'd0};
    int            ld_fill [4] = '{0, 0, 0, 0};
    bit            ld_req = 1'b0;
    int            underflow = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ld_req) begin
                fcnt[i] <= ld_fill[i];
                frd[i]  <= 0;
            end else if (bus.up_pop[i]) begin
                if (fcnt[i] == 0) begin
                    underflow <= underflow + 1;
                end else begin
                    fout[i] <= DW'(i * 16 + frd[i]);
                    frd[i]  <= frd[i] + 1;
                    fcnt[i] <= fcnt[i] - 1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bus.up_empty[i]          = (fcnt[i] == 0);
            bus.up_data[i*DW +: DW]  = fout[i];
        end
    end

    // Monitor, sampled on the falling edge.
    int            cyc = 0;
    int            onehot_err = 0;
    logic [3:0]    prev_g = 4'd0;
    int            pop_idx [$];
    int            pop_cyc [$];
    logic [DW-1:0] push_dat [$];
    int            push_cyc [$];
    logic [3:0]    gnt_q [$];

    function automatic int oh2i(input logic [3:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.up_pop != 4'd0) begin
            if (!$onehot(bus.up_pop)) onehot_err = onehot_err + 1;
            pop_idx.push_back(oh2i(bus.up_pop));
            pop_cyc.push_back(cyc);
        end
        if (bus.dn_push) begin
            push_dat.push_back(bus.dn_data);
            push_cyc.push_back(cyc);
        end
        if (bus.grant != prev_g && bus.grant != 4'd0) gnt_q.push_back(bus.grant);
        prev_g = bus.grant;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int f0, input int f1, input int f2, input int f3);
        ld_fill = '{f0, f1, f2, f3};
        ld_req  = 1'b1;
        step();
        ld_req  = 1'b0;
    endtask

    task automatic wait_pops(input int target, input string nm);
        int k = 0;
        while (pop_idx.size() < target && k < 60) begin
            step();
            k++;
        end
        if (pop_idx.size() < target) chk({nm, "_pop_timeout"}, 32'(pop_idx.size()), 32'(target));
    endtask

    task automatic wait_grants(input int target, input string nm);
        int k = 0;
        while (gnt_q.size() < target && k < 40) begin
            step();
            k++;
        end
        if (gnt_q.size() < target) chk({nm, "_grant_timeout"}, 32'(gnt_q.size()), 32'(target));
    endtask

    // Scenario table: FIFO fill levels and the hand-derived grant runs {fifo, pops}.
    typedef struct packed {
        logic [15:0] fill;
        logic [3:0]  nruns;
        logic [39:0] runs;
    } vec_t;

    function automatic logic [15:0] fills(input int f0, input int f1, input int f2, input int f3);
        return {4'(f3), 4'(f2), 4'(f1), 4'(f0)};
    endfunction

    function automatic logic [4:0] run_e(input int i, input int c);
        return {2'(i), 3'(c)};
    endfunction

    function automatic logic [39:0] runs8(input logic [4:0] r0, input logic [4:0] r1,
                                          input logic [4:0] r2, input logic [4:0] r3,
                                          input logic [4:0] r4, input logic [4:0] r5,
                                          input logic [4:0] r6, input logic [4:0] r7);
        return {r7, r6, r5, r4, r3, r2, r1, r0};
    endfunction

    vec_t vecs [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b_pop, b_push, b_g, uf0, start, total, j, ri, rc;
        int nxt [4];
        vec_t v;

        vecs[0] = '{fill: fills(0, 0, 6, 0), nruns: 4'd2,
                    runs: runs8(run_e(2, 4), run_e(2, 2), 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0)};
        vecs[1] = '{fill: fills(8, 8, 8, 8), nruns: 4'd8,
                    runs: runs8(run_e(0, 4), run_e(1, 4), run_e(2, 4), run_e(3, 4),
                                run_e(0, 4), run_e(1, 4), run_e(2, 4), run_e(3, 4))};
        vecs[2] = '{fill: fills(1, 0, 3, 5), nruns: 4'd4,
                    runs: runs8(run_e(0, 1), run_e(2, 3), run_e(3, 4), run_e(3, 1),
                                5'd0, 5'd0, 5'd0, 5'd0)};
        vecs[3] = '{fill: fills(0, 0, 0, 1), nruns: 4'd1,
                    runs: runs8(run_e(3, 1), 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0)};
        vecs[4] = '{fill: fills(2, 5, 0, 0), nruns: 4'd3,
                    runs: runs8(run_e(0, 2), run_e(1, 4), run_e(1, 1), 5'd0, 5'd0, 5'd0, 5'd0, 5'd0)};

        reset        = 1'b1;
        bus.dn_pausa = 1'b0;
        bus.dn_full  = 1'b0;
        step();
        step();
        chk("rst_up_pop",  32'(bus.up_pop),  32'd0);
        chk("rst_dn_push", 32'(bus.dn_push), 32'd0);
        chk("rst_dn_data", 32'(bus.dn_data), 32'd0);
        chk("rst_grant",   32'(bus.grant),   32'd0);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_err_ovf", 32'(bus.err_ovf), 32'd0);

        for (int vi = 0; vi < 5; vi++) begin
            v = vecs[vi];
            reset = 1'b1;
            step();
            load(int'(v.fill[3:0]), int'(v.fill[7:4]), int'(v.fill[11:8]), int'(v.fill[15:12]));
            reset  = 1'b0;
            start  = cyc;
            b_pop  = pop_idx.size();
            b_push = push_dat.size();
            b_g    = gnt_q.size();
            uf0    = underflow;
            total  = 0;
            for (int r = 0; r < int'(v.nruns); r++) total += int'(v.runs[r*5 +: 3]);
            for (int k = 0; k < 400 && (push_dat.size() - b_push) < total; k++) step();
            repeat (8) step();

            chk($sformatf("v%0d_push_count", vi),  32'(push_dat.size() - b_push), 32'(total));
            chk($sformatf("v%0d_pop_count", vi),   32'(pop_idx.size() - b_pop),   32'(total));
            chk($sformatf("v%0d_grant_count", vi), 32'(gnt_q.size() - b_g),       32'(v.nruns));
            nxt = '{0, 0, 0, 0};
            j = 0;
            for (int r = 0; r < int'(v.nruns); r++) begin
                ri = int'(v.runs[r*5+3 +: 2]);
                rc = int'(v.runs[r*5 +: 3]);
                if (b_g + r < gnt_q.size())
                    chk($sformatf("v%0d_grant%0d", vi, r), 32'(gnt_q[b_g+r]), 32'(4'd1 << ri));
                for (int c = 0; c < rc; c++) begin
                    if (b_pop + j < pop_idx.size()) begin
                        chk($sformatf("v%0d_pop%0d_src", vi, j), 32'(pop_idx[b_pop+j]), 32'(ri));
                        if (c > 0)
                            chk($sformatf("v%0d_pop%0d_spacing", vi, j),
                                32'(pop_cyc[b_pop+j] - pop_cyc[b_pop+j-1]), 32'd2);
                    end
                    if (b_push + j < push_dat.size() && b_pop + j < pop_cyc.size()) begin
                        chk($sformatf("v%0d_push%0d_data", vi, j),
                            32'(push_dat[b_push+j]), 32'(ri * 16 + nxt[ri]));
                        chk($sformatf("v%0d_push%0d_latency", vi, j),
                            32'(push_cyc[b_push+j] - pop_cyc[b_pop+j]), 32'd2);
                    end
                    nxt[ri]++;
                    j++;
                end
            end
            if (vi == 0 && b_pop < pop_cyc.size())
                chk("v0_first_pop_cycle", 32'(pop_cyc[b_pop] - start), 32'd2);
            chk($sformatf("v%0d_underflow", vi), 32'(underflow - uf0), 32'd0);
            chk($sformatf("v%0d_end_grant", vi), 32'(bus.grant), 32'd0);
            chk($sformatf("v%0d_end_busy", vi),  32'(bus.busy),  32'd0);
        end
        chk("pop_onehot", 32'(onehot_err), 32'd0);

        // Pause after FIFO 1's second pop: word 2 still pushed, grant released to ptr 2.
        reset = 1'b1;
        step();
        load(0, 6, 0, 0);
        reset  = 1'b0;
        b_pop  = pop_idx.size();
        b_push = push_dat.size();
        b_g    = gnt_q.size();
        wait_pops(b_pop + 2, "pausa");
        step();
        bus.dn_pausa = 1'b1;
        repeat (6) step();
        chk("pausa_pops",   32'(pop_idx.size() - b_pop),   32'd2);
        chk("pausa_pushes", 32'(push_dat.size() - b_push), 32'd2);
        if (b_push + 1 < push_dat.size()) chk("pausa_word2", 32'(push_dat[b_push+1]), 32'd17);
        chk("pausa_grant",   32'(bus.grant), 32'd0);
        chk("pausa_busy",    32'(bus.busy),  32'd0);
        chk("pausa_left",    32'(fcnt[1]),   32'd4);
        chk("pausa_no_regrant", 32'(gnt_q.size() - b_g), 32'd1);
        load(0, 4, 3, 0);
        bus.dn_pausa = 1'b0;
        b_g = gnt_q.size();
        wait_grants(b_g + 1, "pausa_resume");
        if (b_g < gnt_q.size()) chk("pausa_next_grant", 32'(gnt_q[b_g]), 32'h4);

        // Single word in FIFO 3: one pop, one push, pointer wraps to 0.
        reset = 1'b1;
        step();
        load(0, 0, 0, 1);
        reset  = 1'b0;
        b_pop  = pop_idx.size();
        b_push = push_dat.size();
        uf0    = underflow;
        wait_pops(b_pop + 1, "wrap");
        repeat (8) step();
        chk("wrap_pops",   32'(pop_idx.size() - b_pop),   32'd1);
        chk("wrap_pushes", 32'(push_dat.size() - b_push), 32'd1);
        if (b_push < push_dat.size()) chk("wrap_word", 32'(push_dat[b_push]), 32'd48);
        chk("wrap_underflow", 32'(underflow - uf0), 32'd0);
        b_g = gnt_q.size();
        load(0, 1, 0, 1);
        wait_grants(b_g + 1, "wrap_next");
        if (b_g < gnt_q.size()) chk("wrap_next_grant", 32'(gnt_q[b_g]), 32'h2);

        // Push into a full downstream FIFO sets the sticky overflow flag.
        reset = 1'b1;
        step();
        load(1, 0, 0, 0);
        reset = 1'b0;
        b_pop = pop_idx.size();
        wait_pops(b_pop + 1, "ovf");
        bus.dn_full = 1'b1;
        step();
        chk("ovf_before_push", 32'(bus.err_ovf), 32'd0);
        step();
        chk("ovf_push_issued", 32'(bus.dn_push), 32'd1);
        chk("ovf_not_yet",     32'(bus.err_ovf), 32'd0);
        step();
        chk("ovf_set", 32'(bus.err_ovf), 32'd1);
        bus.dn_full = 1'b0;
        repeat (5) step();
        chk("ovf_sticky", 32'(bus.err_ovf), 32'd1);
        reset = 1'b1;
        #1;
        chk("ovf_cleared", 32'(bus.err_ovf), 32'd0);
        step();

        // Reset in GAP while a push is on the bus; pointer must restart at 0.
        load(1, 5, 0, 0);
        reset = 1'b0;
        b_pop = pop_idx.size();
        wait_pops(b_pop + 3, "rstgap");
        chk("rstgap_push_live", 32'(bus.dn_push), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstgap_up_pop",  32'(bus.up_pop),  32'd0);
        chk("rstgap_dn_push", 32'(bus.dn_push), 32'd0);
        chk("rstgap_grant",   32'(bus.grant),   32'd0);
        chk("rstgap_busy",    32'(bus.busy),    32'd0);
        b_push = push_dat.size();
        b_g    = gnt_q.size();
        step();
        load(2, 3, 0, 0);
        reset = 1'b0;
        wait_grants(b_g + 1, "rstgap_regrant");
        if (b_g < gnt_q.size()) chk("rstgap_grant_ptr0", 32'(gnt_q[b_g]), 32'h1);
        for (int k = 0; k < 30 && push_dat.size() == b_push; k++) step();
        if (b_push < push_dat.size()) chk("rstgap_first_push", 32'(push_dat[b_push]), 32'd0);
        else chk("rstgap_push_timeout", 32'(push_dat.size()), 32'(b_push + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
